// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller.
//   state_e          : controller FSM encoding
//   CMD_WR_BIT       : command byte bit selecting write (1) or read (0)
//   CMD_INC_BIT      : command byte bit enabling address auto-increment
//   ADDR_LED         : register whose contents drive the board LEDs
//   ID_VALUE_DEFAULT : constant returned by read-only register 0
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int         CMD_WR_BIT       = 7;
  localparam int         CMD_INC_BIT      = 6;
  localparam int         ADDR_LED         = 1;
  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
//   clk       : destination clock
//   rst       : asynchronous, active-high reset (loads RESET_VAL)
//   d_i       : asynchronous input
//   q_o       : input synchronized to clk
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_controller.sv
// Command/register controller sitting beside SPI_slave. Byte 0 of each
// ssel frame is a command (bit7 write/read, bit6 auto-increment, low bits
// start address); following bytes are written into, or streamed out of,
// a 2**ADDR_WIDTH byte register bank. Register 0 reads ID_VALUE and is
// write-protected; register 1 drives the LEDs.
//   clk_25mhz     : system clock
//   reset         : asynchronous, active-high reset
//   ssel          : raw SPI chip-select (active low, asynchronous)
//   byte_received : pulse, received_data valid
//   received_data : byte shifted in from the master
//   data_needed   : pulse, next MISO byte required
//   data_to_send  : byte offered for the next transfer
//   led           : contents of register 1
//   wr_strobe     : one-cycle pulse per accepted register write
//   wr_addr       : address of the accepted write
//   wr_data       : data of the accepted write
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  ssel,
  input  logic                  byte_received,
  input  logic [7:0]            received_data,
  input  logic                  data_needed,
  output logic [7:0]            data_to_send,
  output logic [7:0]            led,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_e     state_q, state_d;
  addr_t      addr_q, addr_d;
  logic       inc_q, inc_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] dts_q, dts_d;
  logic       wr_strobe_q, wr_strobe_d;
  addr_t      wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       fa_prev_q;
  logic [7:0] regs_q [DEPTH];

  logic  ssel_sync;
  logic  frame_active, frame_rise, frame_fall;
  addr_t cmd_addr;
  logic  cmd_inc, cmd_wr;

  // The synchronizer resets to "frame active" and fa_prev_q to 1, so a frame
  // already in progress when reset releases is never mistaken for a new one;
  // the controller waits for ssel to go high and fall again.
  sync_2ff #(.RESET_VAL(1'b0)) u_ssel_sync (
    .clk (clk_25mhz),
    .rst (reset),
    .d_i (ssel),
    .q_o (ssel_sync)
  );

  assign frame_active = ~ssel_sync;
  assign frame_rise   = frame_active & ~fa_prev_q;
  assign frame_fall   = ~frame_active & fa_prev_q;

  assign cmd_addr = received_data[ADDR_WIDTH-1:0];
  assign cmd_inc  = received_data[CMD_INC_BIT];
  assign cmd_wr   = received_data[CMD_WR_BIT];

  function automatic logic [7:0] rd(input addr_t a);
    return (a == '0) ? ID_VALUE : regs_q[a];
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    inc_d       = inc_q;
    fc_d        = fc_q;
    dts_d       = dts_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    // A fall seen in IDLE only follows a reset taken mid-frame; that frame was
    // abandoned and is not counted.
    if (frame_fall && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      fc_d    = fc_q + 8'd1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_rise)  state_d = ST_CMD;
          if (data_needed) dts_d = fc_q;
        end
        ST_CMD: begin
          if (data_needed) dts_d = fc_q;
          if (byte_received) begin
            addr_d  = cmd_addr;
            inc_d   = cmd_inc;
            state_d = cmd_wr ? ST_WRITE : ST_READ;
            // Simultaneous read request: decode first, then serve the request
            // from the commanded address.
            if (data_needed && !cmd_wr) begin
              dts_d  = rd(cmd_addr);
              addr_d = cmd_addr + addr_t'(cmd_inc);
            end
          end
        end
        ST_WRITE: begin
          if (byte_received) begin
            if (addr_q != '0) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = received_data;
            end
            addr_d = addr_q + addr_t'(inc_q);
          end
        end
        ST_READ: begin
          if (data_needed) begin
            dts_d  = rd(addr_q);
            addr_d = addr_q + addr_t'(inc_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      inc_q       <= 1'b0;
      fc_q        <= '0;
      dts_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fa_prev_q   <= 1'b1;
      // NOTE: the bank is small and its contents are architecturally visible
      // (LEDs, reads after reset), so it is built from resettable flops rather
      // than an unreset RAM.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inc_q       <= inc_d;
      fc_q        <= fc_d;
      dts_q       <= dts_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fa_prev_q   <= frame_active;
      if (wr_strobe_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign data_to_send = dts_q;
  assign led          = regs_q[ADDR_LED];
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench for spi_reg_controller: table of frames plus
// hand-written sequences for stale pulses and reset mid-frame. Expected MISO
// bytes and write strobes are queued when stimulus is driven and compared
// when the DUT produces them.
module tb_spi_reg_controller;

  logic       clk_25mhz = 1'b0;
  logic       reset;
  logic       ssel;
  logic       byte_received;
  logic [7:0] received_data;
  logic       data_needed;
  logic [7:0] data_to_send;
  logic [7:0] led;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  spi_reg_controller #(.ADDR_WIDTH(4), .ID_VALUE(8'hA5)) dut (
    .clk_25mhz     (clk_25mhz),
    .reset         (reset),
    .ssel          (ssel),
    .byte_received (byte_received),
    .received_data (received_data),
    .data_needed   (data_needed),
    .data_to_send  (data_to_send),
    .led           (led),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: expected MISO bytes and expected {wr_addr, wr_data}.
  logic [7:0]  miso_q [$];
  logic [11:0] strobe_q [$];

  logic dn_d1;
  always @(posedge clk_25mhz or posedge reset)
    if (reset) dn_d1 <= 1'b0;
    else       dn_d1 <= data_needed;

  always @(negedge clk_25mhz) begin
    if (!reset && dn_d1) begin
      if (miso_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL miso_unexpected: got %0h, expected no request", data_to_send);
      end else begin
        check("miso", data_to_send, miso_q.pop_front());
      end
    end
    if (!reset && wr_strobe) begin
      if (strobe_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h, expected no strobe", wr_addr, wr_data);
      end else begin
        check("wr_strobe", {wr_addr, wr_data}, strobe_q.pop_front());
      end
    end
  end

  typedef struct {
    int          n;      // bytes in frame (command included)
    logic [31:0] mosi;   // byte i at [31-8*i -: 8]
    logic [31:0] miso;   // expected MISO for request i, same layout
    bit          simul;  // data_needed coincides with byte_received
    int          nwr;
    logic [11:0] w0, w1; // expected {addr, data} strobes
    logic [7:0]  led;
  } frame_t;

  function automatic frame_t mk(input int n, input logic [31:0] mosi, input logic [31:0] miso,
                                input bit simul, input int nwr, input logic [11:0] w0,
                                input logic [11:0] w1, input logic [7:0] led);
    frame_t f;
    f.n = n; f.mosi = mosi; f.miso = miso; f.simul = simul;
    f.nwr = nwr; f.w0 = w0; f.w1 = w1; f.led = led;
    return f;
  endfunction

  task automatic req(input logic [7:0] exp);
    @(negedge clk_25mhz);
    data_needed = 1'b1;
    miso_q.push_back(exp);
    @(negedge clk_25mhz);
    data_needed = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_dn, input logic [7:0] exp);
    @(negedge clk_25mhz);
    received_data = b;
    byte_received = 1'b1;
    if (with_dn) begin
      data_needed = 1'b1;
      miso_q.push_back(exp);
    end
    @(negedge clk_25mhz);
    byte_received = 1'b0;
    data_needed   = 1'b0;
  endtask

  task automatic run_frame(input frame_t f);
    if (f.nwr > 0) strobe_q.push_back(f.w0);
    if (f.nwr > 1) strobe_q.push_back(f.w1);
    @(negedge clk_25mhz);
    ssel = 1'b0;
    repeat (4) @(negedge clk_25mhz);
    req(f.miso[31 -: 8]);
    for (int i = 0; i < f.n; i++) begin
      send_byte(f.mosi[31-8*i -: 8], f.simul && (i < f.n-1), f.miso[23-8*i -: 8]);
      if (!f.simul && i < f.n-1) req(f.miso[23-8*i -: 8]);
    end
    @(negedge clk_25mhz);
    ssel = 1'b1;
    repeat (4) @(negedge clk_25mhz);
    check("wr_pending", strobe_q.size(), 0);
    check("led", led, f.led);
  endtask

  frame_t frames [8];

  initial begin
    frames[0] = mk(3, 32'hC13C7700, 32'h00000000, 0, 2, {4'h1, 8'h3C}, {4'h2, 8'h77}, 8'h3C);
    frames[1] = mk(4, 32'h40000000, 32'h01A53C77, 0, 0, '0, '0, 8'h3C);
    frames[2] = mk(3, 32'hCF112200, 32'h02020200, 0, 1, {4'hF, 8'h11}, '0, 8'h3C);
    frames[3] = mk(3, 32'h4F000000, 32'h0311A500, 0, 0, '0, '0, 8'h3C);
    frames[4] = mk(3, 32'h02000000, 32'h04777700, 0, 0, '0, '0, 8'h3C);
    frames[5] = mk(1, 32'h81000000, 32'h05000000, 0, 0, '0, '0, 8'h3C);
    frames[6] = mk(3, 32'h41000000, 32'h063C7700, 1, 0, '0, '0, 8'h3C);
    frames[7] = mk(2, 32'hC5990000, 32'h07070000, 1, 1, {4'h5, 8'h99}, '0, 8'h3C);

    reset = 1'b1; ssel = 1'b1; byte_received = 1'b0; data_needed = 1'b0;
    received_data = 8'h00;
    repeat (3) @(negedge clk_25mhz);
    check("rst_data_to_send", data_to_send, 8'h00);
    check("rst_led", led, 8'h00);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_wr_data", wr_data, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk_25mhz);

    for (int i = 0; i < 8; i++) run_frame(frames[i]);

    // Stale pulses while idle: only the frame counter is offered, no write.
    send_byte(8'hC1, 1'b1, 8'h08);
    send_byte(8'h3C, 1'b0, 8'h00);
    repeat (3) @(negedge clk_25mhz);
    check("stale_led", led, 8'h3C);
    check("stale_wr_pending", strobe_q.size(), 0);

    // Reset asserted in the middle of a read frame.
    @(negedge clk_25mhz);
    ssel = 1'b0;
    repeat (4) @(negedge clk_25mhz);
    req(8'h08);
    send_byte(8'h41, 1'b0, 8'h00);
    req(8'h3C);
    repeat (2) @(negedge clk_25mhz);
    #5 reset = 1'b1;
    #1;
    check("midrst_led", led, 8'h00);
    check("midrst_data_to_send", data_to_send, 8'h00);
    check("midrst_wr_strobe", wr_strobe, 1'b0);
    repeat (2) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    ssel = 1'b1;
    repeat (4) @(negedge clk_25mhz);
    run_frame(mk(2, 32'h01000000, 32'h00000000, 0, 0, '0, '0, 8'h00));

    repeat (3) @(negedge clk_25mhz);
    check("miso_pending", miso_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
- Command/register controller that sits beside SPI_slave and sequences its byte stream: interprets byte 0 of each ssel frame as a command, then writes received bytes into, or streams bytes out of, a small register bank.
- Replaces the plain byte-echo loop. Register 1 drives the board LEDs; every write is also exported as a strobe for downstream logic.

Parameters:
ADDR_WIDTH, 4, register address width; the bank holds 2**ADDR_WIDTH bytes.
ID_VALUE, 8'hA5, constant returned by read-only register 0.

Ports:
clk_25mhz  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-high reset
ssel  input  1  raw SPI chip-select, active low, asynchronous to clk_25mhz
byte_received  input  1  one-cycle pulse from SPI_slave: received_data is valid
received_data  input  8  byte shifted in from the master
data_needed  input  1  one-cycle pulse from SPI_slave: next MISO byte is required
data_to_send  output  8  byte offered to SPI_slave for the next transfer
led  output  8  contents of register 1
wr_strobe  output  1  one-cycle pulse on every accepted register write
wr_addr  output  ADDR_WIDTH  address of the accepted write
wr_data  output  8  data of the accepted write

Behaviour:
- Reset (async, active-high): state IDLE, all registers 0, frame_count 0, data_to_send 0, led 0, wr_strobe 0, wr_addr 0, wr_data 0.
- ssel is passed through a 2-FF synchronizer. frame_active = NOT ssel_sync.
- Command byte: bit7 = write (1) / read (0); bit6 = auto-increment enable; bits[ADDR_WIDTH-1:0] = start address. Remaining bits are ignored.
- States:
  - IDLE: when frame_active rises, go to CMD.
  - CMD: on byte_received, latch addr and inc from the command byte. Go to WRITE if bit7 = 1, otherwise READ.
  - WRITE: on each byte_received, reg[addr] <= received_data, then addr <= addr + inc. wr_strobe/wr_addr/wr_data are registered with the write, so they are valid the cycle after the pulse.
  - READ: on each data_needed, data_to_send <= reg[addr], then addr <= addr + inc. Bytes received in READ are discarded.
  - Any state: frame_active falling (ssel high after sync) returns to IDLE and frame_count increments (8-bit, wraps 255 -> 0).
- data_needed in IDLE or CMD: data_to_send <= frame_count.
- data_to_send updates exactly 1 clock after data_needed and otherwise holds its value.
- Simultaneous events in CMD (byte_received and data_needed in the same cycle, with a read command): decode first. data_to_send <= reg[cmd addr], addr <= cmd addr + inc, and the state goes to READ.
- If the simultaneous command is a write: data_to_send <= frame_count.
- Register 0 always reads ID_VALUE. Writes to address 0 are dropped, with no wr_strobe and addr still incrementing. Register 1 drives led continuously.
- Address arithmetic is modulo 2**ADDR_WIDTH: auto-increment from the top address wraps to 0.
- byte_received or data_needed while IDLE: data is ignored and no state change occurs (stale pulse after ssel deasserts).
- ssel deasserted mid-frame: bytes already written stay written, a partial byte is never written, and the next frame restarts in CMD.
- Reset mid-frame: everything returns to reset values immediately. The frame in progress is abandoned and the next ssel fall starts a new frame.

Decomposition:
- Shared package (spi_reg_pkg): state encoding (IDLE/CMD/WRITE/READ), command bit positions (CMD_WR_BIT = 7, CMD_INC_BIT = 6), ADDR_LED = 1, ID_VALUE default.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with async reset, used for ssel. The register bank stays inline.

Test Plan:
- Write with auto-increment: frame {8'hC1, 8'h3C, 8'h77} -> led = 8'h3C; reg2 = 8'h77; two wr_strobe pulses with addr 1 then 2; frame_count = 1.
- Read with auto-increment after the above: frame {8'h40, 8'h00, 8'h00, 8'h00} -> MISO bytes are frame_count (1), then 8'hA5, 8'h3C, 8'h77.
- Wrap and reg0 protection: write frame {8'hCF, 8'h11, 8'h22} with ADDR_WIDTH = 4 -> reg15 = 8'h11; reg0 still reads 8'hA5; exactly one wr_strobe.
- Non-increment read: frame {8'h02, x, x} after reg2 = 8'h77 -> both data bytes return 8'h77.
- Abort: ssel raised after the command byte 8'h81 and 4 bits of data -> no write, state IDLE; next frame's first MISO byte is the incremented frame_count.
- Async reset asserted mid-READ -> led, data_to_send and frame_count are 0 immediately. A following read of reg1 returns 8'h00.
